// File: rtl/route_reserve_arbiter.sv
// rtl/route_reserve_arbiter.sv - per-output route reservation arbiter with round-robin selection
//
// Each router output port is either FREE or LOCKED to one input port. Inputs
// ask for an output with req_valid/req_port, win it through a per-output
// round-robin pointer, and hand it back with a relieve pulse once the tail
// flit has gone through.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous reset, active-high
//   req_valid   [P]      input i requests an output, held until its grant
//   req_port    [P*RW]   slice i: requested output index of input i
//   relieve     [P]      input i releases the output it owns (one-cycle pulse)
//   grant       [P]      one-cycle pulse: reservation accepted for input i
//   out_locked  [P]      output o is reserved
//   out_owner   [P*RW]   slice o: input owning output o (crossbar select)
//   req_error   1        a valid request named an output index >= P
module route_reserve_arbiter #(
  parameter int P             = 5,
  parameter int REQUEST_WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [P-1:0]               req_valid,
  input  logic [P*REQUEST_WIDTH-1:0] req_port,
  input  logic [P-1:0]               relieve,
  output logic [P-1:0]               grant,
  output logic [P-1:0]               out_locked,
  output logic [P*REQUEST_WIDTH-1:0] out_owner,
  output logic                       req_error
);

  typedef enum logic {FREE = 1'b0, LOCKED = 1'b1} outState_t;

  outState_t                state   [P];
  logic [REQUEST_WIDTH-1:0] owner   [P];
  logic [REQUEST_WIDTH-1:0] rrPtr   [P];

  logic [REQUEST_WIDTH-1:0] reqPort [P];
  logic [REQUEST_WIDTH-1:0] winner  [P];
  logic [P-1:0]             portInRange;
  logic [P-1:0]             ownsOutput;
  logic [P-1:0]             lockNow;
  logic [P-1:0]             freeNow;
  logic [P-1:0]             nextGrant;

  always_comb begin
    for (int i = 0; i < P; i++) begin
      reqPort[i]     = req_port[i*REQUEST_WIDTH +: REQUEST_WIDTH];
      portInRange[i] = int'(reqPort[i]) < P;
    end
  end

  // An input that already holds an output may not compete for another one;
  // this also blocks a same-cycle relieve+request until the release has landed.
  always_comb begin
    ownsOutput = '0;
    for (int o = 0; o < P; o++)
      for (int i = 0; i < P; i++)
        if (state[o] == LOCKED && owner[o] == REQUEST_WIDTH'(i))
          ownsOutput[i] = 1'b1;
  end

  // Round-robin search per output, starting at rrPtr and wrapping P-1 -> 0.
  // A LOCKED output never arbitrates, so the edge that frees it cannot regrant it.
  always_comb begin
    int idx;
    idx = 0;
    for (int o = 0; o < P; o++) begin
      lockNow[o] = 1'b0;
      freeNow[o] = 1'b0;
      winner[o]  = '0;
      if (state[o] == FREE) begin
        for (int k = 0; k < P; k++) begin
          idx = int'(rrPtr[o]) + k;
          if (idx >= P)
            idx = idx - P;
          if (!lockNow[o] && req_valid[idx] && reqPort[idx] == REQUEST_WIDTH'(o) &&
              !ownsOutput[idx] && !grant[idx]) begin
            lockNow[o] = 1'b1;
            winner[o]  = REQUEST_WIDTH'(idx);
          end
        end
      end else begin
        for (int i = 0; i < P; i++)
          if (relieve[i] && owner[o] == REQUEST_WIDTH'(i))
            freeNow[o] = 1'b1;
      end
    end
  end

  // Each input names a single output, so at most one output can pick it.
  always_comb begin
    nextGrant = '0;
    for (int o = 0; o < P; o++)
      for (int i = 0; i < P; i++)
        if (lockNow[o] && winner[o] == REQUEST_WIDTH'(i))
          nextGrant[i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < P; o++) begin
        state[o] <= FREE;
        owner[o] <= '0;
        rrPtr[o] <= '0;
      end
      grant     <= '0;
      req_error <= 1'b0;
    end else begin
      for (int o = 0; o < P; o++) begin
        case (state[o])
          FREE: begin
            if (lockNow[o]) begin
              state[o] <= LOCKED;
              owner[o] <= winner[o];
              rrPtr[o] <= (int'(winner[o]) == P - 1) ? '0 : winner[o] + 1'b1;
            end
          end
          LOCKED: begin
            // owner keeps its last value after release
            if (freeNow[o])
              state[o] <= FREE;
          end
          default: state[o] <= FREE;
        endcase
      end
      grant     <= nextGrant;
      req_error <= |(req_valid & ~portInRange);
    end
  end

  always_comb begin
    for (int o = 0; o < P; o++) begin
      out_locked[o]                                   = (state[o] == LOCKED);
      out_owner[o*REQUEST_WIDTH +: REQUEST_WIDTH]     = owner[o];
    end
  end

endmodule

// File: tb/tb_route_reserve_arbiter.sv
// tb/tb_route_reserve_arbiter.sv - directed self-checking bench for route_reserve_arbiter
module tb_route_reserve_arbiter;

  localparam int P  = 5;
  localparam int RW = 3;

  logic            clk;
  logic            rst;
  logic [P-1:0]    req_valid;
  logic [P*RW-1:0] req_port;
  logic [P-1:0]    relieve;
  logic [P-1:0]    grant;
  logic [P-1:0]    out_locked;
  logic [P*RW-1:0] out_owner;
  logic            req_error;

  int checks   = 0;
  int failures = 0;

  route_reserve_arbiter #(.P(P), .REQUEST_WIDTH(RW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_port   (req_port),
    .relieve    (relieve),
    .grant      (grant),
    .out_locked (out_locked),
    .out_owner  (out_owner),
    .req_error  (req_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(input int i, input int port);
    req_valid[i]          = 1'b1;
    req_port[i*RW +: RW]  = RW'(port);
  endtask

  function automatic logic [RW-1:0] ownerOf(input int o);
    return out_owner[o*RW +: RW];
  endfunction

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_port  = '0;
    relieve   = '0;
    tick();
    tick();
    checkEq("reset_grant",  32'(grant), 32'h0);
    checkEq("reset_locked", 32'(out_locked), 32'h0);
    checkEq("reset_owner",  32'(out_owner), 32'h0);
    checkEq("reset_error",  32'(req_error), 32'h0);
    rst = 1'b0;
    tick();

    // single request from FREE, latency 1
    setReq(2, 4);
    tick();
    checkEq("single_grant",  32'(grant), 32'b00100);
    checkEq("single_locked", 32'(out_locked), 32'b10000);
    checkEq("single_owner",  32'(ownerOf(4)), 32'd2);
    req_valid[2] = 1'b0;
    tick();
    checkEq("single_grant_pulse", 32'(grant), 32'h0);
    checkEq("single_still_locked", 32'(out_locked), 32'b10000);
    relieve[2] = 1'b1;
    tick();
    relieve = '0;
    checkEq("single_freed", 32'(out_locked), 32'h0);
    checkEq("single_owner_kept", 32'(ownerOf(4)), 32'd2);

    // three-way contention for output 1, rr starts at 0
    setReq(0, 1); setReq(1, 1); setReq(3, 1);
    tick();
    checkEq("rr_first_grant", 32'(grant), 32'b00001);
    checkEq("rr_first_owner", 32'(ownerOf(1)), 32'd0);
    req_valid[0] = 1'b0;
    tick();
    checkEq("rr_waiting", 32'(grant), 32'h0);
    relieve[0] = 1'b1;
    tick();
    relieve = '0;
    checkEq("rr_free_no_regrant", 32'(grant), 32'h0);
    checkEq("rr_free_unlocked", 32'(out_locked), 32'h0);
    tick();
    checkEq("rr_second_grant", 32'(grant), 32'b00010);
    checkEq("rr_second_owner", 32'(ownerOf(1)), 32'd1);
    req_valid[1] = 1'b0;
    relieve[1] = 1'b1;
    tick();
    relieve = '0;
    checkEq("rr_second_free_grant", 32'(grant), 32'h0);
    tick();
    checkEq("rr_third_grant", 32'(grant), 32'b01000);
    checkEq("rr_third_owner", 32'(ownerOf(1)), 32'd3);
    req_valid[3] = 1'b0;
    relieve[3] = 1'b1;
    tick();
    relieve = '0;
    checkEq("rr_all_free", 32'(out_locked), 32'h0);

    // two outputs lock in the same cycle
    setReq(0, 2); setReq(3, 4);
    tick();
    checkEq("par_grant",  32'(grant), 32'b01001);
    checkEq("par_locked", 32'(out_locked), 32'b10100);
    req_valid = '0;
    relieve = 5'b01001;
    tick();
    relieve = '0;
    checkEq("par_freed", 32'(out_locked), 32'h0);

    // out-of-range request
    setReq(1, 6);
    tick();
    checkEq("err_pulse1", 32'(req_error), 32'h1);
    checkEq("err_no_grant", 32'(grant), 32'h0);
    tick();
    checkEq("err_pulse2", 32'(req_error), 32'h1);
    checkEq("err_no_lock", 32'(out_locked), 32'h0);
    req_valid = '0;
    tick();
    checkEq("err_clear", 32'(req_error), 32'h0);

    // relieve from a non-owner is ignored
    setReq(0, 3);
    tick();
    checkEq("rel_grant", 32'(grant), 32'b00001);
    checkEq("rel_locked", 32'(out_locked), 32'b01000);
    req_valid = '0;
    relieve[4] = 1'b1;
    tick();
    relieve = '0;
    checkEq("rel_foreign_ignored", 32'(out_locked), 32'b01000);
    relieve[0] = 1'b1;
    tick();
    relieve = '0;
    checkEq("rel_owner_frees", 32'(out_locked), 32'h0);

    // waiting on a locked output, then relieve and re-request together
    setReq(0, 2);
    tick();
    checkEq("wait_lock_grant", 32'(grant), 32'b00001);
    req_valid = '0;
    setReq(1, 2);
    tick();
    checkEq("wait_no_grant", 32'(grant), 32'h0);
    checkEq("wait_no_error", 32'(req_error), 32'h0);
    checkEq("wait_owner", 32'(ownerOf(2)), 32'd0);
    relieve[0] = 1'b1;
    setReq(0, 2);
    tick();
    relieve = '0;
    checkEq("same_cycle_free", 32'(out_locked), 32'h0);
    checkEq("same_cycle_no_grant", 32'(grant), 32'h0);
    tick();
    checkEq("same_cycle_rr_grant", 32'(grant), 32'b00010);
    checkEq("same_cycle_owner", 32'(ownerOf(2)), 32'd1);
    req_valid[1] = 1'b0;
    relieve[1] = 1'b1;
    tick();
    relieve = '0;
    checkEq("requeue_gap", 32'(grant), 32'h0);
    tick();
    checkEq("requeue_grant", 32'(grant), 32'b00001);
    checkEq("requeue_owner", 32'(ownerOf(2)), 32'd0);
    req_valid = '0;

    // reset with two outputs locked
    setReq(3, 4);
    tick();
    checkEq("prerst_grant", 32'(grant), 32'b01000);
    checkEq("prerst_locked", 32'(out_locked), 32'b10100);
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkEq("rst_locked", 32'(out_locked), 32'h0);
    checkEq("rst_owner",  32'(out_owner), 32'h0);
    checkEq("rst_grant",  32'(grant), 32'h0);
    tick();
    checkEq("postrst_idle_grant", 32'(grant), 32'h0);
    setReq(1, 0);
    tick();
    checkEq("postrst_grant",  32'(grant), 32'b00010);
    checkEq("postrst_locked", 32'(out_locked), 32'b00001);
    req_valid = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
